// File: rtl/aes_shiftrows_pipe_if.sv
// rtl/aes_shiftrows_pipe_if.sv - block handshake bundle for the ShiftRows pipeline
//
// Carries one input stream (valid/ready/mode/state) and one output stream of
// the same shape.
//   slave  : the pipeline side (consumes in_*, produces out_*)
//   master : the producer/consumer side around the pipeline
// Parameter W is the state width in bits (32 * columns).

interface aes_shiftrows_pipe_if #(
   parameter int W = 128
);
   logic         in_valid_i;
   logic         in_ready_o;
   logic         in_mode_i;
   logic [W-1:0] in_state_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         out_mode_o;
   logic [W-1:0] out_state_o;

   modport slave (
      input  in_valid_i, in_mode_i, in_state_i, out_ready_i,
      output in_ready_o, out_valid_o, out_mode_o, out_state_o
   );

   modport master (
      output in_valid_i, in_mode_i, in_state_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_mode_o, out_state_o
   );
endinterface

// File: rtl/aes_shiftrows_pipe.sv
// rtl/aes_shiftrows_pipe.sv - AES (Inv)ShiftRows stage with main + skid buffering
//
// Applies ShiftRows (mode 0, rotate left) or InvShiftRows (mode 1, rotate
// right) to a column-major NB-column state and buffers the result in a main
// register (drives the outputs) backed by one skid register.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   flush_i   : synchronous clear of all buffered blocks
//   bus       : aes_shiftrows_pipe_if.slave (in/out valid, ready, mode, state)
//   blk_cnt_o : 16-bit output transfer count, only when AES_SHIFTROWS_PIPE_CNT_EN
//               is defined
// Optional feature macro: AES_SHIFTROWS_PIPE_CNT_EN

module aes_shiftrows_pipe #(
   parameter int NB = 4,
   parameter int W  = 32*NB
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic flush_i,
`ifdef AES_SHIFTROWS_PIPE_CNT_EN
   output logic [15:0] blk_cnt_o,
`endif
   aes_shiftrows_pipe_if.slave bus
);

   if (!(NB == 4 || NB == 6 || NB == 8) || W != 32*NB) begin : g_bad_cfg
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8 and W must equal 32*NB");
   end

   // Row offsets: rows 2 and 3 shift one further for the 8-column state.
   function automatic int row_off(input int r);
      if (r == 0)      return 0;
      else if (r == 1) return 1;
      else if (NB == 8) return r + 1;
      else             return r;
   endfunction

   // Pure byte permutation; byte k sits at bits [W-1-8k -: 8], row k%4, col k/4.
   function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
      logic [W-1:0] o;
      int src;
      o = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < NB; c++) begin
            if (inv) src = (c - row_off(r) + NB) % NB;
            else     src = (c + row_off(r)) % NB;
            o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
         end
      end
      return o;
   endfunction

   logic         main_valid;
   logic         main_mode;
   logic [W-1:0] main_state;
   logic         skid_valid;
   logic         skid_mode;
   logic [W-1:0] skid_state;
   logic [W-1:0] xf_state;
   logic         in_fire;
   logic         main_open;

   assign xf_state  = shift_rows(bus.in_state_i, bus.in_mode_i);
   // in_ready is purely registered, so accepting only depends on skid_valid.
   assign in_fire   = bus.in_valid_i && !skid_valid;
   // Main can take new data this edge: empty, or its block leaves now.
   assign main_open = !main_valid || bus.out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         main_mode  <= 1'b0;
         main_state <= '0;
         skid_valid <= 1'b0;
         skid_mode  <= 1'b0;
         skid_state <= '0;
      end else if (flush_i) begin
         // Flush wins over any simultaneous accept.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_open) begin
         if (skid_valid) begin
            // Skid is older than anything arriving; in_ready was 0 so nothing arrives.
            main_state <= skid_state;
            main_mode  <= skid_mode;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            main_state <= xf_state;
            main_mode  <= bus.in_mode_i;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_fire) begin
         skid_state <= xf_state;
         skid_mode  <= bus.in_mode_i;
         skid_valid <= 1'b1;
      end
   end

   assign bus.in_ready_o  = !skid_valid;
   assign bus.out_valid_o = main_valid;
   assign bus.out_mode_o  = main_mode;
   assign bus.out_state_o = main_state;

`ifdef AES_SHIFTROWS_PIPE_CNT_EN
   logic out_fire;
   assign out_fire = main_valid && bus.out_ready_i;

   // Counts every output transfer, including one coinciding with a flush.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         blk_cnt_o <= 16'd0;
      else if (out_fire) blk_cnt_o <= blk_cnt_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// tb/tb_aes_shiftrows_pipe.sv - randomized scoreboard bench for aes_shiftrows_pipe

module tb_aes_shiftrows_pipe;

   localparam logic [127:0] KAT_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] KAT_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   logic clk;
   logic rst;
   logic flush;

   aes_shiftrows_pipe_if #(.W(128)) bus4 ();
   aes_shiftrows_pipe_if #(.W(192)) bus6 ();
   aes_shiftrows_pipe_if #(.W(256)) bus8 ();

`ifdef AES_SHIFTROWS_PIPE_CNT_EN
   logic [15:0] blk_cnt4, blk_cnt6, blk_cnt8;
`endif

   aes_shiftrows_pipe #(.NB(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef AES_SHIFTROWS_PIPE_CNT_EN
      .blk_cnt_o(blk_cnt4),
`endif
      .bus(bus4)
   );
   aes_shiftrows_pipe #(.NB(6)) u_dut6 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef AES_SHIFTROWS_PIPE_CNT_EN
      .blk_cnt_o(blk_cnt6),
`endif
      .bus(bus6)
   );
   aes_shiftrows_pipe #(.NB(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
`ifdef AES_SHIFTROWS_PIPE_CNT_EN
      .blk_cnt_o(blk_cnt8),
`endif
      .bus(bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cnt_exp = 0;
   logic [128:0] q[$];   // {mode, state} of blocks held by the DUT, oldest first

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: lift each row out as a list of bytes and rotate it whole.
   function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input bit inv);
      byte unsigned row[$];
      int tbl[4];
      int top;
      logic [255:0] o;
      o = '0;
      top = 32*nb;
      if (nb == 8) tbl = '{0, 1, 3, 4};
      else         tbl = '{0, 1, 2, 3};
      for (int r = 0; r < 4; r++) begin
         row.delete();
         for (int c = 0; c < nb; c++) row.push_back(s[top-1-8*(4*c+r) -: 8]);
         for (int k = 0; k < tbl[r]; k++) begin
            if (!inv) row.push_back(row.pop_front());
            else      row.push_front(row.pop_back());
         end
         for (int c = 0; c < nb; c++) o[top-1-8*(4*c+r) -: 8] = row[c];
      end
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_outputs();
      check("out_valid", 256'(bus4.out_valid_o), 256'(q.size() != 0));
      check("in_ready", 256'(bus4.in_ready_o), 256'(q.size() < 2));
      if (q.size() != 0) begin
         check("out_state", 256'(bus4.out_state_o), 256'(q[0][127:0]));
         check("out_mode", 256'(bus4.out_mode_o), 256'(q[0][128]));
      end
   endtask

   // Called at a falling edge: drive, predict the coming rising edge, check after it.
   task automatic cycle(input bit v, input bit m, input logic [127:0] d, input bit rdy, input bit fl);
      bit ifire, ofire;
      logic [255:0] t;
      bus4.in_valid_i  = v;
      bus4.in_mode_i   = m;
      bus4.in_state_i  = d;
      bus4.out_ready_i = rdy;
      flush = fl;
      ifire = v && (q.size() < 2);
      ofire = rdy && (q.size() != 0);
      t = ref_shift({128'b0, d}, 4, m);
      @(posedge clk);
      if (ofire) cnt_exp++;
      if (fl) q.delete();
      else begin
         if (ofire) void'(q.pop_front());
         if (ifire) q.push_back({m, t[127:0]});
      end
      @(negedge clk);
      flush = 1'b0;
      check_outputs();
   endtask

   logic [191:0] x6, y6;
   logic [255:0] x8, y8, tmp;

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      bus4.in_valid_i = 1'b0; bus4.in_mode_i = 1'b0; bus4.in_state_i = '0; bus4.out_ready_i = 1'b0;
      bus6.in_valid_i = 1'b0; bus6.in_mode_i = 1'b0; bus6.in_state_i = '0; bus6.out_ready_i = 1'b1;
      bus8.in_valid_i = 1'b0; bus8.in_mode_i = 1'b0; bus8.in_state_i = '0; bus8.out_ready_i = 1'b1;
      #3;
      check("rst_out_valid", 256'(bus4.out_valid_o), 256'(0));
      check("rst_in_ready", 256'(bus4.in_ready_o), 256'(1));
      check("rst_out_state", 256'(bus4.out_state_o), 256'(0));
      check("rst_out_mode", 256'(bus4.out_mode_o), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      check_outputs();

      // Known answers, one-cycle latency from empty
      cycle(1, 0, KAT_IN, 1, 0);
      check("kat_enc", 256'(bus4.out_state_o), 256'(KAT_OUT));
      cycle(1, 1, KAT_OUT, 1, 0);
      check("kat_dec", 256'(bus4.out_state_o), 256'(KAT_IN));
      cycle(0, 0, '0, 1, 0);

      // Back-to-back mixed modes
      cycle(1, 0, rand128(), 1, 0);
      cycle(1, 1, rand128(), 1, 0);
      cycle(1, 0, rand128(), 1, 0);
      cycle(0, 0, '0, 1, 0);

      // Backpressure: A in main, B in skid, then drain
      cycle(1, 0, rand128(), 0, 0);
      cycle(1, 1, rand128(), 0, 0);
      check("bp_in_ready_low", 256'(bus4.in_ready_o), 256'(0));
      cycle(1, 0, rand128(), 0, 0);
      cycle(0, 0, '0, 1, 0);
      check("bp_in_ready_back", 256'(bus4.in_ready_o), 256'(1));
      cycle(0, 0, '0, 1, 0);

      // Flush with two held plus a simultaneous input
      cycle(1, 0, rand128(), 0, 0);
      cycle(1, 1, rand128(), 0, 0);
      cycle(1, 0, rand128(), 0, 1);
      check("flush_out_valid", 256'(bus4.out_valid_o), 256'(0));
      cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 1, 0);

      // Asynchronous reset between edges with data held
      cycle(1, 0, rand128(), 0, 0);
      cycle(1, 1, rand128(), 0, 0);
      bus4.in_valid_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 256'(bus4.out_valid_o), 256'(0));
      check("arst_in_ready", 256'(bus4.in_ready_o), 256'(1));
      check("arst_out_state", 256'(bus4.out_state_o), 256'(0));
      #1 rst = 1'b0;
      q.delete();
      cnt_exp = 0;
      @(negedge clk);
      check_outputs();
      cycle(1, 1, rand128(), 1, 0);
      cycle(0, 0, '0, 1, 0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 3) != 0, 1'($urandom), rand128(),
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      cycle(0, 0, '0, 1, 0);
      cycle(0, 0, '0, 1, 0);
      bus4.out_ready_i = 1'b0;

      // NB=6 / NB=8 round trips
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) x6[32*j +: 32] = $urandom;
         for (int j = 0; j < 8; j++) x8[32*j +: 32] = $urandom;
         tmp = ref_shift({64'b0, x6}, 6, 0);
         y6 = tmp[191:0];
         y8 = ref_shift(x8, 8, 0);
         bus6.in_valid_i = 1'b1; bus6.in_mode_i = 1'b0; bus6.in_state_i = x6;
         bus8.in_valid_i = 1'b1; bus8.in_mode_i = 1'b0; bus8.in_state_i = x8;
         @(posedge clk); @(negedge clk);
         check("nb6_enc", 256'(bus6.out_state_o), 256'(y6));
         check("nb8_enc", bus8.out_state_o, y8);
         bus6.in_mode_i = 1'b1; bus6.in_state_i = y6;
         bus8.in_mode_i = 1'b1; bus8.in_state_i = y8;
         @(posedge clk); @(negedge clk);
         check("nb6_roundtrip", 256'(bus6.out_state_o), 256'(x6));
         check("nb8_roundtrip", bus8.out_state_o, x8);
         check("nb8_mode", 256'(bus8.out_mode_o), 256'(1));
         bus6.in_valid_i = 1'b0;
         bus8.in_valid_i = 1'b0;
      end

`ifdef AES_SHIFTROWS_PIPE_CNT_EN
      check("blk_cnt", 256'(blk_cnt4), 256'(cnt_exp[15:0]));
      rst = 1'b1;
      #1 rst = 1'b0;
      q.delete();
      cnt_exp = 0;
      @(negedge clk);
      cycle(1, 0, rand128(), 1, 0);
      for (int i = 0; i < 65537; i++) cycle(i < 65536, 0, rand128(), 1, 0);
      check("blk_cnt_wrap", 256'(blk_cnt4), 256'(16'd1));
      check("blk_cnt_model", 256'(blk_cnt4), 256'(cnt_exp[15:0]));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/aes_shiftrows_pipe.md
AES_SHIFTROWS_PIPE -- requirements
Module: aes_shiftrows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, state width in 32-bit columns; legal values 4, 6, 8; any other value is an elaboration error.
REQ-002 SHALL have parameter W, default 32*NB, state width in bits; derived only, never overridden.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  synchronous clear of all buffered data.
REQ-006 SHALL have port in_valid_i  input  1  input block valid.
REQ-007 SHALL have port in_ready_o  output  1  module can accept a block.
REQ-008 SHALL have port in_mode_i  input  1  0=ShiftRows (encrypt, rotate left), 1=InvShiftRows (decrypt, rotate right).
REQ-009 SHALL have port in_state_i  input  W  state; byte 0 at bits [W-1:W-8]; column-major, byte k = row k%4, column k/4.
REQ-010 SHALL have port out_valid_o  output  1  output block valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts output.
REQ-012 SHALL have port out_mode_o  output  1  mode travelling with the output block.
REQ-013 SHALL have port out_state_o  output  W  transformed state, same byte order as input.

Function
REQ-014 Row shift offsets C0..C3: NB=4 -> 0,1,2,3; NB=6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
REQ-015 Mode 0: out row r, column c = in row r, column (c+Cr) mod NB; mode 1: in row r, column (c-Cr) mod NB.
REQ-016 Mode SHALL be sampled per block with in_state_i and never affects other blocks in flight.
REQ-017 Input transfer when in_valid_i && in_ready_o at a rising edge; output transfer when out_valid_o && out_ready_i.
REQ-018 Storage: main register (drives outputs) plus one skid register; the transform is applied before storage.
REQ-019 Latency: block accepted at edge N appears on out_state_o with out_valid_o=1 after edge N (1 cycle) when the main register is empty or drained at edge N.
REQ-020 in_ready_o SHALL equal !skid_valid, taken directly from a register with no combinational path from out_ready_i.
REQ-021 Accept with main empty or main draining: data goes to main. Accept with main full and not draining: data goes to skid.
REQ-022 Main draining with skid full: skid moves to main, skid clears; simultaneous input is impossible since in_ready_o=0.
REQ-023 Sustained out_ready_i=1 SHALL give one block per cycle throughput; order SHALL be strictly FIFO.
REQ-024 out_state_o and out_mode_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-025 flush_i=1 at an edge SHALL clear both valids; a simultaneous input transfer is dropped (flush wins).

Reset
REQ-026 rst_i asserted: out_valid_o=0, in_ready_o=1, out_state_o=0, out_mode_o=0, skid cleared, immediately and without a clock.
REQ-027 Reset mid-transfer discards all in-flight blocks; the first accept after deassertion behaves as from empty.

Configuration
REQ-028 Macro AES_SHIFTROWS_PIPE_CNT_EN defined: extra port blk_cnt_o output 16, count of output transfers, reset 0, wraps 0xFFFF->0, unaffected by flush_i.
REQ-029 Macro undefined: no blk_cnt_o port and no counter logic; all other behaviour identical.

Verification
REQ-030 NB=4, mode 0, in d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5 one cycle later.
REQ-031 NB=4, mode 1, in d4bf5d30e0b452aeb84111f11e2798e5 -> out d42711aee0bf98f1b8b45de51e415230; NB=6 and NB=8 round-trip (mode 0 then mode 1) of random data returns input exactly.
REQ-032 Back-to-back blocks A,B,C with out_ready_i=1 -> out A,B,C on consecutive cycles, mixed modes each correct.
REQ-033 out_ready_i=0 while sending A,B -> A in main, B in skid, in_ready_o=0; raise out_ready_i -> A then B, in_ready_o=1 one cycle after A leaves.
REQ-034 flush_i with A,B held plus simultaneous input C -> out_valid_o=0, in_ready_o=1 next cycle, C never appears.
REQ-035 rst_i pulse between clock edges with data held -> out_valid_o=0 immediately; with AES_SHIFTROWS_PIPE_CNT_EN, 65537 transfers -> blk_cnt_o=1.
